// File: rtl/cycle_display_pkg.sv
// Shared types, constants and segment decode for the cycle count display.
// Imported by the serial BCD converter and the display driver top.
package cycle_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    localparam int              DIGITS      = 4;
    localparam int              COUNT_W     = 14;
    localparam logic [13:0]     MAX_DISPLAY = 14'd9999;

    // Segments are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0]      SEG_BLANK   = 7'b1111111;
    localparam logic [6:0]      SEG_DASH    = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cycle_display_driver_bcd.sv
// Serial double-dabble: 14-bit binary to four BCD digits over 14 clocks.
// Ports: iClk, iRst_n, i_start, i_bin -> o_busy, o_done, o_bcd, o_ovf.
module bcd_serial_converter
    import cycle_display_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_bin,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_bcd,
    output logic               o_ovf
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [COUNT_W-1:0] r_bin;
    logic [COUNT_W-1:0] w_bin_nx;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_nx;
    logic [15:0]        w_adj;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nx;
    logic               r_ovf;
    logic               w_ovf_nx;

    // Add-3 on every nibble that would reach >=10 after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_bin_nx   = r_bin;
        w_bcd_nx   = r_bcd;
        w_cnt_nx   = r_cnt;
        w_ovf_nx   = r_ovf;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_bin_nx   = i_bin;
                    w_bcd_nx   = '0;
                    w_cnt_nx   = 4'd13;
                    w_ovf_nx   = (i_bin > MAX_DISPLAY);
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                w_bcd_nx = {w_adj[14:0], r_bin[COUNT_W-1]};
                w_bin_nx = {r_bin[COUNT_W-2:0], 1'b0};
                if (r_cnt == 4'd0)
                    w_state_nx = LATCH;
                else
                    w_cnt_nx = r_cnt - 4'd1;
            end
            LATCH:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_bin   <= w_bin_nx;
            r_bcd   <= w_bcd_nx;
            r_cnt   <= w_cnt_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == LATCH);
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/cycle_display_driver.sv
// Samples a cycle count, converts it to BCD and scans it onto a 4-digit display.
// Ports: iClk, iRst_n, iCycles, iLoad -> oBusy, oOverflow, oSeg, oAn.
module cycle_display_driver
    import cycle_display_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
)(
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [COUNT_W-1:0] iCycles,
    input  logic               iLoad,
    output logic               oBusy,
    output logic               oOverflow,
    output logic [6:0]         oSeg,
    output logic [3:0]         oAn
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_digits;
    logic          r_ovf;

    logic          w_busy;
    logic          w_done;
    logic          w_conv_ovf;
    logic [15:0]   w_bcd;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg;
    logic [3:0]    w_an;

    bcd_serial_converter u_conv (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .i_start (iLoad),
        .i_bin   (iCycles),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_conv_ovf)
    );

    // A digit is blanked when it and every higher digit are zero.
    always_comb begin
        w_digit = r_digits[{r_idx, 2'b00} +: 4];
        w_blank = 1'b0;
        if (BLANK_LEADING != 0) begin
            case (r_idx)
                2'd3: w_blank = (r_digits[15:12] == 4'd0);
                2'd2: w_blank = (r_digits[15:8] == 8'd0);
                2'd1: w_blank = (r_digits[15:4] == 12'd0);
                default: w_blank = 1'b0;
            endcase
        end
        if (r_ovf)
            w_seg = SEG_DASH;
        else if (w_blank)
            w_seg = SEG_BLANK;
        else
            w_seg = seg_decode(w_digit);
        w_an = ~(4'b0001 << r_idx);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
            oSeg     <= SEG_BLANK;
            oAn      <= 4'b1111;
        end else begin
            if (r_presc == PRESC_TC) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_done) begin
                r_digits <= w_bcd;
                r_ovf    <= w_conv_ovf;
            end
            oSeg <= w_seg;
            oAn  <= w_an;
        end
    end

    assign oBusy     = w_busy;
    assign oOverflow = r_ovf;

endmodule

// File: tb/tb_cycle_display_driver.sv
// Directed bench for cycle_display_driver with SCAN_DIV=4.
// Two instances share stimulus: u_dut1 blanks leading zeros, u_dut0 does not.
module tb_cycle_display_driver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] cyc   = '0;
    logic        load  = 1'b0;

    logic        busy1, ovf1, busy0, ovf0;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    always #5 clk = ~clk;

    cycle_display_driver #(.SCAN_DIV(4), .BLANK_LEADING(1)) u_dut1 (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iCycles   (cyc),
        .iLoad     (load),
        .oBusy     (busy1),
        .oOverflow (ovf1),
        .oSeg      (seg1),
        .oAn       (an1)
    );

    cycle_display_driver #(.SCAN_DIV(4), .BLANK_LEADING(0)) u_dut0 (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iCycles   (cyc),
        .iLoad     (load),
        .oBusy     (busy0),
        .oOverflow (ovf0),
        .oSeg      (seg0),
        .oAn       (an0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [13:0] v);
        cyc  = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Record the segment pattern seen in each digit slot over 20 clocks.
    task automatic capture(output logic [27:0] s1, output logic [27:0] s0);
        s1 = 'x;
        s0 = 'x;
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (an1 == ~(4'b0001 << k)) s1[7*k +: 7] = seg1;
                if (an0 == ~(4'b0001 << k)) s0[7*k +: 7] = seg0;
            end
        end
    endtask

    task automatic test_reset();
        logic [27:0] s1, s0;
        logic [3:0]  exp_an;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (an1 !== 4'b1111) begin
            errors++;
            $display("FAIL reset_an got %b exp 1111", an1);
        end
        checks++;
        if (seg1 !== SB) begin
            errors++;
            $display("FAIL reset_seg got %b exp %b", seg1, SB);
        end
        checks++;
        if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b ovf=%b exp 0 0", busy1, ovf1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (an1 !== 4'b1110 || seg1 !== S0) begin
            errors++;
            $display("FAIL first_edge got an=%b seg=%b exp 1110 %b", an1, seg1, S0);
        end
        for (int i = 2; i <= 16; i++) begin
            tick();
            exp_an = ~(4'b0001 << ((i - 1) / 4));
            checks++;
            if (an1 !== exp_an) begin
                errors++;
                $display("FAIL scan_an[%0d] got %b exp %b", i, an1, exp_an);
            end
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {SB, SB, SB, S0}) begin
            errors++;
            $display("FAIL idle_slots got %h exp %h", s1, {SB, SB, SB, S0});
        end
        checks++;
        if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_flags got busy=%b ovf=%b exp 0 0", busy1, ovf1);
        end
    endtask

    task automatic test_convert();
        logic [27:0] s1, s0;
        int n;
        do_load(14'd1234);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %b exp 1", busy1);
        end
        wait_idle(n);
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len got %0d exp 15", n);
        end
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_1234 got %b exp 0", ovf1);
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {S1, S2, S3, S4}) begin
            errors++;
            $display("FAIL slots_1234 got %h exp %h", s1, {S1, S2, S3, S4});
        end
    endtask

    task automatic test_overflow();
        logic [27:0] s1, s0;
        int n;
        do_load(14'd10000);
        wait_idle(n);
        checks++;
        if (n != 15 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got n=%0d ovf=%b exp 15 1", n, ovf1);
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {SD, SD, SD, SD} || s0 !== {SD, SD, SD, SD}) begin
            errors++;
            $display("FAIL slots_ovf got %h %h exp %h", s1, s0, {SD, SD, SD, SD});
        end
        do_load(14'd9999);
        wait_idle(n);
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got %b exp 0", ovf1);
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {S9, S9, S9, S9}) begin
            errors++;
            $display("FAIL slots_9999 got %h exp %h", s1, {S9, S9, S9, S9});
        end
    endtask

    task automatic test_blanking();
        logic [27:0] s1, s0;
        int n;
        do_load(14'd7);
        wait_idle(n);
        capture(s1, s0);
        checks++;
        if (s1 !== {SB, SB, SB, S7}) begin
            errors++;
            $display("FAIL blank_7 got %h exp %h", s1, {SB, SB, SB, S7});
        end
        checks++;
        if (s0 !== {S0, S0, S0, S7}) begin
            errors++;
            $display("FAIL noblank_7 got %h exp %h", s0, {S0, S0, S0, S7});
        end
        do_load(14'd70);
        wait_idle(n);
        capture(s1, s0);
        checks++;
        if (s0 !== {S0, S0, S7, S0}) begin
            errors++;
            $display("FAIL noblank_70 got %h exp %h", s0, {S0, S0, S7, S0});
        end
        checks++;
        if (s1 !== {SB, SB, S7, S0}) begin
            errors++;
            $display("FAIL blank_70 got %h exp %h", s1, {SB, SB, S7, S0});
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] s1, s0;
        logic [6:0]  exp_seg;
        do_load(14'd500);
        cyc = 14'd42;
        for (int e = 1; e <= 31; e++) begin
            load = (e == 5 || e == 15 || e == 16);
            tick();
            load = 1'b0;
            if (e == 15) begin
                checks++;
                if (busy1 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_n15 got busy=%b exp 0", busy1);
                end
            end
            if (e == 16) begin
                checks++;
                if (busy1 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_n16 got busy=%b exp 1", busy1);
                end
            end
            if (e >= 16) begin
                case (an1)
                    4'b1110: exp_seg = S0;
                    4'b1101: exp_seg = S0;
                    4'b1011: exp_seg = S5;
                    default: exp_seg = SB;
                endcase
                checks++;
                if (seg1 !== exp_seg) begin
                    errors++;
                    $display("FAIL b2b_500[%0d] got %b exp %b", e, seg1, exp_seg);
                end
            end
            if (e == 31) begin
                checks++;
                if (busy1 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_n31 got busy=%b exp 0", busy1);
                end
            end
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {SB, SB, S4, S2}) begin
            errors++;
            $display("FAIL slots_42 got %h exp %h", s1, {SB, SB, S4, S2});
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] s1, s0;
        do_load(14'd9876);
        for (int e = 1; e <= 6; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags got busy=%b ovf=%b exp 0 0", busy1, ovf1);
        end
        checks++;
        if (an1 !== 4'b1111 || seg1 !== SB) begin
            errors++;
            $display("FAIL rstmid_out got an=%b seg=%b exp 1111 %b", an1, seg1, SB);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (an1 !== 4'b1110 || seg1 !== S0) begin
            errors++;
            $display("FAIL rstmid_first got an=%b seg=%b exp 1110 %b", an1, seg1, S0);
        end
        capture(s1, s0);
        checks++;
        if (s1 !== {SB, SB, SB, S0} || s0 !== {S0, S0, S0, S0}) begin
            errors++;
            $display("FAIL rstmid_slots got %h %h exp %h %h",
                     s1, s0, {SB, SB, SB, S0}, {S0, S0, S0, S0});
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy got %b exp 0", busy1);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
